// File: rtl/outbuf_pingpong_multi.sv
// ---------------------------------------------------------------------------
// outbuf_pingpong_multi
//
// Double-buffered (ping-pong) output frame buffer for NUM_BLOCKS LED panel
// segments. The image loader writes the back bank of each block while the row
// scan driver reads the front bank of all blocks in parallel. Front and back
// only trade places at a frame boundary (SWAP_REQ, then FRAME_END), so the
// panel never shows a half-written frame.
//
// Handshake: the writer raises SWAP_REQ for one cycle once every back bank is
// complete. SWAP_BUSY stays high until the scan driver's FRAME_END pulse;
// the following cycle is the swap cycle, and at its closing edge FRONT_BANK
// toggles and SWAP_DONE pulses high for exactly one cycle. Writes up to and
// including the swap cycle land in the bank that becomes visible; writes from
// the SWAP_DONE cycle on land in the bank that was just retired. Extra
// SWAP_REQ pulses while a swap is outstanding are dropped, not queued.
//
// Ports
//   CLK, RESET_N             clock, asynchronous active-low reset
//   WR_ENA/WR_ADDR/WR_DATA   per-block write enable and address, shared data
//   WR_ERR, WR_ERR_CLR       sticky out-of-range write flag and its clear
//   RD_EN/RD_ADDR            shared read strobe and address (front bank)
//   RD_DATA/RD_VALID         registered read data of all blocks, valid flag
//   FRAME_END, SWAP_REQ      frame boundary pulse, swap request pulse
//   SWAP_BUSY, SWAP_DONE     swap pending, swap completed pulse
//   FRONT_BANK               bank currently being displayed
//   DBG_STATE                swap FSM state (0 idle, 1 pending, 2 swap)
// ---------------------------------------------------------------------------
module outbuf_pingpong_multi #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048,
  parameter int NUM_BLOCKS = 3
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic [NUM_BLOCKS-1:0]            WR_ENA,
  input  logic [NUM_BLOCKS*ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0]            WR_DATA,
  output logic                             WR_ERR,
  input  logic                             WR_ERR_CLR,
  input  logic                             RD_EN,
  input  logic [ADDR_WIDTH-1:0]            RD_ADDR,
  output logic [NUM_BLOCKS*DATA_WIDTH-1:0] RD_DATA,
  output logic                             RD_VALID,
  input  logic                             FRAME_END,
  input  logic                             SWAP_REQ,
  output logic                             SWAP_BUSY,
  output logic                             SWAP_DONE,
  output logic                             FRONT_BANK,
  output logic [1:0]                       DBG_STATE
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int NB = NUM_BLOCKS;
  // One extra bit so DEPTH = 2**AW is representable in comparisons.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SWAP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             front_q, front_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [NB*DW-1:0] rd_data_q, rd_data_d;
  logic [NB*DW-1:0] rd_word;
  logic [NB-1:0]    wr_ok;
  logic [NB-1:0]    wr_bad;
  logic             rd_in_range;

  assign rd_in_range = {1'b0, RD_ADDR} < DEPTH_W;

  // Per-block storage: 2*DEPTH words, bank 1 sits above bank 0 (the bank is
  // the top part of the internal address; with DEPTH = 2**AW it is exactly
  // the MSB). Reads always use the front bank and writes the back bank, so a
  // read and a write can never touch the same word.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [DW-1:0] mem [2*DEPTH];
    logic [AW-1:0] wr_addr;
    logic          wr_in_range;
    logic [AW:0]   wr_idx;
    logic [AW:0]   rd_idx;

    assign wr_addr     = WR_ADDR[k*AW +: AW];
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    assign wr_ok[k]    = WR_ENA[k] & wr_in_range;
    assign wr_bad[k]   = WR_ENA[k] & ~wr_in_range;

    // Back bank is the one not being displayed.
    assign wr_idx = front_q ? {1'b0, wr_addr} : DEPTH_W + {1'b0, wr_addr};
    // Out-of-range reads are forced to zero later; clamp the index so the
    // array is never addressed past its end.
    assign rd_idx = !rd_in_range ? '0 :
                    (front_q ? DEPTH_W + {1'b0, RD_ADDR} : {1'b0, RD_ADDR});

    always_ff @(posedge CLK) begin
      if (wr_ok[k]) begin
        mem[wr_idx] <= WR_DATA;
      end
    end

    assign rd_word[k*DW +: DW] = mem[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (SWAP_REQ && FRAME_END) begin
          state_d = ST_SWAP;
        end else if (SWAP_REQ) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (FRAME_END) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The toggle happens at the edge that leaves SWAP, so anything issued in
    // the swap cycle itself still sees the old front bank.
    front_d = front_q ^ (state_q == ST_SWAP);
    done_d  = (state_q == ST_SWAP);
    busy_d  = (state_d == ST_PEND);

    // Clear wins over a same-cycle out-of-range write.
    err_d = WR_ERR_CLR ? 1'b0 : (err_q | (|wr_bad));

    rd_valid_d = RD_EN;
    rd_data_d  = rd_data_q;
    if (RD_EN) begin
      rd_data_d = rd_in_range ? rd_word : '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      front_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign WR_ERR     = err_q;
  assign RD_DATA    = rd_data_q;
  assign RD_VALID   = rd_valid_q;
  assign SWAP_BUSY  = busy_q;
  assign SWAP_DONE  = done_q;
  assign FRONT_BANK = front_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_outbuf_pingpong_multi.sv
// ---------------------------------------------------------------------------
// tb_outbuf_pingpong_multi
//
// Bench for outbuf_pingpong_multi configured with DEPTH=2000 (non power of
// two) and three blocks. Inputs change 1 ns after the rising edge; outputs are
// compared 1 ns after the rising edge that produced them.
//
// The reference model tracks memory per (block, bank, address) in an
// associative array, a "swap requested" flag and a "toggle at next edge"
// flag. Words never written are unknown and are masked out of data checks.
// ---------------------------------------------------------------------------
module tb_outbuf_pingpong_multi;

  localparam int DW    = 24;
  localparam int AW    = 11;
  localparam int DEPTH = 2000;
  localparam int NB    = 3;

  localparam logic [71:0] ALL = '1;
  localparam logic [71:0] M0  = 72'hFFFFFF;
  localparam logic [71:0] CBA = {24'h0C0C0C, 24'h0B0B0B, 24'h0A0A0A};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NB-1:0]    wr_ena;
  logic [NB*AW-1:0] wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_err;
  logic             wr_err_clr;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [NB*DW-1:0] rd_data;
  logic             rd_valid;
  logic             frame_end;
  logic             swap_req;
  logic             swap_busy;
  logic             swap_done;
  logic             front_bank;
  logic [1:0]       dbg_state;

  outbuf_pingpong_multi #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .NUM_BLOCKS(NB)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .WR_ENA    (wr_ena),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data),
    .WR_ERR    (wr_err),
    .WR_ERR_CLR(wr_err_clr),
    .RD_EN     (rd_en),
    .RD_ADDR   (rd_addr),
    .RD_DATA   (rd_data),
    .RD_VALID  (rd_valid),
    .FRAME_END (frame_end),
    .SWAP_REQ  (swap_req),
    .SWAP_BUSY (swap_busy),
    .SWAP_DONE (swap_done),
    .FRONT_BANK(front_bank),
    .DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp, input logic [71:0] mask);
    n_checks++;
    if (((act ^ exp) & mask) != '0) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (mask %h) t=%0t", name, act, exp, mask, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [int];
  logic          m_front, m_req, m_toggle, m_done, m_err, m_valid;
  logic [71:0]   m_data, m_known;

  function automatic int key(input int blk, input int bank, input int addr);
    return blk * 8192 + bank * 4096 + addr;
  endfunction

  task automatic model_reset();
    m_front  = 1'b0;
    m_req    = 1'b0;
    m_toggle = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_known  = '1;
  endtask

  // Effect of one rising edge with the inputs currently applied.
  task automatic model_edge();
    logic set_err;
    int   front_i;
    int   a;
    set_err = 1'b0;
    front_i = m_front ? 1 : 0;
    m_valid = rd_en;
    if (rd_en) begin
      a = int'(rd_addr);
      if (a >= DEPTH) begin
        m_data  = '0;
        m_known = '1;
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (m_mem.exists(key(k, front_i, a))) begin
            m_data[k*DW +: DW]  = m_mem[key(k, front_i, a)];
            m_known[k*DW +: DW] = '1;
          end else begin
            m_known[k*DW +: DW] = '0;
          end
        end
      end
    end
    for (int k = 0; k < NB; k++) begin
      a = int'(wr_addr[k*AW +: AW]);
      if (wr_ena[k]) begin
        if (a < DEPTH) m_mem[key(k, 1 - front_i, a)] = wr_data;
        else           set_err = 1'b1;
      end
    end
    m_err  = wr_err_clr ? 1'b0 : (m_err | set_err);
    m_done = 1'b0;
    if (m_toggle) begin
      m_front  = ~m_front;
      m_done   = 1'b1;
      m_toggle = 1'b0;
    end else if ((m_req || swap_req) && frame_end) begin
      m_toggle = 1'b1;
      m_req    = 1'b0;
    end else if (swap_req) begin
      m_req = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rd_valid"},  {71'd0, rd_valid},   {71'd0, m_valid},  72'd1);
    chk({tag, ".rd_data"},   rd_data,             m_data,            m_known);
    chk({tag, ".front"},     {71'd0, front_bank}, {71'd0, m_front},  72'd1);
    chk({tag, ".busy"},      {71'd0, swap_busy},  {71'd0, m_req},    72'd1);
    chk({tag, ".done"},      {71'd0, swap_done},  {71'd0, m_done},   72'd1);
    chk({tag, ".wr_err"},    {71'd0, wr_err},     {71'd0, m_err},    72'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wr_ena     = '0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_err_clr = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    frame_end  = 1'b0;
    swap_req   = 1'b0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  we;
    logic [10:0] wa0, wa1, wa2;
    logic [23:0] wd;
    logic        rd;
    logic [10:0] ra;
    logic        req, fe, clr;
    logic        ev;
    logic [71:0] ed, em;
    logic        ef, eb, edn, ee;
  } vec_t;

  vec_t tbl[18];

  // ---------------- test sequence ----------------
  int done_cnt;

  initial begin
    // Field order: we, wa0, wa1, wa2, wd, rd, ra, req, fe, clr,
    //              exp valid, exp data, data mask, exp front, busy, done, err
    tbl[0]  = '{3'b001, 11'd5,    11'd0,    11'd0,    24'h112233, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 72'h0, ALL,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b1, 11'd5,    1'b0, 1'b0, 1'b0, 1'b1, 72'h0, 72'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b0, 11'd0,    1'b1, 1'b1, 1'b0, 1'b0, 72'h0, 72'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 72'h0, 72'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b1, 11'd5,    1'b0, 1'b0, 1'b0, 1'b1, 72'h112233, M0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'b001, 11'd0,    11'd0,    11'd0,    24'h0A0A0A, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 72'h112233, M0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'b010, 11'd0,    11'd0,    11'd0,    24'h0B0B0B, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 72'h112233, M0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3'b100, 11'd0,    11'd0,    11'd0,    24'h0C0C0C, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 72'h112233, M0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b0, 11'd0,    1'b1, 1'b1, 1'b0, 1'b0, 72'h112233, M0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 72'h112233, M0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b1, 11'd0,    1'b0, 1'b0, 1'b0, 1'b1, CBA,   ALL,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, CBA,   ALL,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{3'b010, 11'd0,    11'd2047, 11'd0,    24'hFFFFFF, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, CBA,   ALL,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, CBA,   ALL,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{3'b100, 11'd0,    11'd0,    11'd2000, 24'h777777, 1'b0, 11'd0,    1'b0, 1'b0, 1'b1, 1'b0, CBA,   ALL,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b1, 11'd2047, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0, ALL,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{3'b001, 11'd1999, 11'd0,    11'd0,    24'h123456, 1'b1, 11'd0,    1'b0, 1'b0, 1'b0, 1'b1, CBA,   ALL,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{3'b000, 11'd0,    11'd0,    11'd0,    24'h0,      1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 1'b0, CBA,   ALL,   1'b0, 1'b0, 1'b0, 1'b0};

    // ---- reset state ----
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    chk("reset.front",    {71'd0, front_bank}, 72'd0, 72'd1);
    chk("reset.busy",     {71'd0, swap_busy},  72'd0, 72'd1);
    chk("reset.done",     {71'd0, swap_done},  72'd0, 72'd1);
    chk("reset.rd_valid", {71'd0, rd_valid},   72'd0, 72'd1);
    chk("reset.rd_data",  rd_data,             72'd0, ALL);
    chk("reset.wr_err",   {71'd0, wr_err},     72'd0, 72'd1);
    rst_n = 1'b1;
    cycle();

    // ---- table: swap latency, block packing, hold, range errors ----
    for (int i = 0; i < 18; i++) begin
      wr_ena     = tbl[i].we;
      wr_addr    = {tbl[i].wa2, tbl[i].wa1, tbl[i].wa0};
      wr_data    = tbl[i].wd;
      rd_en      = tbl[i].rd;
      rd_addr    = tbl[i].ra;
      swap_req   = tbl[i].req;
      frame_end  = tbl[i].fe;
      wr_err_clr = tbl[i].clr;
      cycle();
      chk($sformatf("t%0d.rd_valid", i), {71'd0, rd_valid},   {71'd0, tbl[i].ev},  72'd1);
      chk($sformatf("t%0d.rd_data", i),  rd_data,             tbl[i].ed,           tbl[i].em);
      chk($sformatf("t%0d.front", i),    {71'd0, front_bank}, {71'd0, tbl[i].ef},  72'd1);
      chk($sformatf("t%0d.busy", i),     {71'd0, swap_busy},  {71'd0, tbl[i].eb},  72'd1);
      chk($sformatf("t%0d.done", i),     {71'd0, swap_done},  {71'd0, tbl[i].edn}, 72'd1);
      chk($sformatf("t%0d.wr_err", i),   {71'd0, wr_err},     {71'd0, tbl[i].ee},  72'd1);
    end
    idle_inputs();

    // ---- pending swap held for 10 cycles, second request ignored ----
    swap_req = 1'b1;
    cycle();
    chk("pend.busy_first", {71'd0, swap_busy}, 72'd1, 72'd1);
    swap_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      swap_req = (i == 3);
      cycle();
      chk($sformatf("pend.busy%0d", i), {71'd0, swap_busy}, 72'd1, 72'd1);
      chk($sformatf("pend.done%0d", i), {71'd0, swap_done}, 72'd0, 72'd1);
    end
    swap_req  = 1'b0;
    frame_end = 1'b1;
    cycle();
    frame_end = 1'b0;
    chk("pend.busy_swap",  {71'd0, swap_busy},  72'd0, 72'd1);
    chk("pend.front_swap", {71'd0, front_bank}, 72'd0, 72'd1);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (swap_done) done_cnt++;
      check_model($sformatf("pend.after%0d", i));
    end
    chk("pend.done_count", 72'(done_cnt), 72'd1, ALL);
    chk("pend.front_end",  {71'd0, front_bank}, 72'd1, 72'd1);

    // ---- reset while a swap is pending, after one swap ----
    swap_req = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 11'd0;
    wr_ena   = 3'b001;
    wr_addr  = {11'd0, 11'd0, 11'd2040};
    cycle();
    idle_inputs();
    chk("rst.pre_busy",  {71'd0, swap_busy},  72'd1, 72'd1);
    chk("rst.pre_err",   {71'd0, wr_err},     72'd1, 72'd1);
    chk("rst.pre_valid", {71'd0, rd_valid},   72'd1, 72'd1);
    chk("rst.pre_front", {71'd0, front_bank}, 72'd1, 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.front",    {71'd0, front_bank}, 72'd0, 72'd1);
    chk("rst.busy",     {71'd0, swap_busy},  72'd0, 72'd1);
    chk("rst.done",     {71'd0, swap_done},  72'd0, 72'd1);
    chk("rst.rd_valid", {71'd0, rd_valid},   72'd0, 72'd1);
    chk("rst.rd_data",  rd_data,             72'd0, ALL);
    chk("rst.wr_err",   {71'd0, wr_err},     72'd0, 72'd1);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    frame_end = 1'b1;
    cycle();
    frame_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("rst.post_done%0d", i),  {71'd0, swap_done},  72'd0, 72'd1);
      chk($sformatf("rst.post_front%0d", i), {71'd0, front_bank}, 72'd0, 72'd1);
      chk($sformatf("rst.post_busy%0d", i),  {71'd0, swap_busy},  72'd0, 72'd1);
    end

    // ---- back-to-back frames: write next frame while reading current ----
    for (int f = 0; f < 5; f++) begin
      for (int a = 0; a < DEPTH; a++) begin
        wr_ena  = 3'b111;
        wr_addr = {11'((a + 14) % DEPTH), 11'((a + 7) % DEPTH), 11'(a)};
        wr_data = 24'($urandom);
        rd_en   = (f != 0);
        rd_addr = 11'(a);
        cycle();
        check_model($sformatf("frame%0d", f));
      end
      idle_inputs();
      swap_req  = 1'b1;
      frame_end = 1'b1;
      cycle();
      idle_inputs();
      cycle();
      chk($sformatf("frame%0d.done", f),  {71'd0, swap_done},  72'd1, 72'd1);
      chk($sformatf("frame%0d.front", f), {71'd0, front_bank}, {71'd0, 1'(f % 2 == 0)}, 72'd1);
    end

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      wr_ena = 3'($urandom_range(0, 7));
      for (int k = 0; k < NB; k++) begin
        wr_addr[k*AW +: AW] = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(DEPTH, 2047))
                                                           : 11'($urandom_range(0, DEPTH - 1));
      end
      wr_data    = 24'($urandom);
      rd_en      = 1'($urandom_range(0, 1));
      rd_addr    = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(DEPTH, 2047))
                                               : 11'($urandom_range(0, DEPTH - 1));
      swap_req   = ($urandom_range(0, 19) == 0);
      frame_end  = ($urandom_range(0, 14) == 0);
      wr_err_clr = ($urandom_range(0, 29) == 0);
      cycle();
      check_model("rand");
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the sequence above is a fixed number of cycles.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
